// File: rtl/lcd_spi_pkg.sv
// Shared types and constants for the 12864 LCD SPI arbiter.
package lcd_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2,
    ST_HOLD = 2'd3
  } lcd_state_e;

  // Word layout: {ctl[1:0], byte[7:0]}
  localparam int LCD_DW         = 10;
  localparam int LCD_CTL_CS_BIT = 9;  // 1 = chip select inactive
  localparam int LCD_CTL_DC_BIT = 8;  // data/command select

  // Parked word: CS inactive, D/C high, zero payload (10'h300)
  localparam logic [LCD_DW-1:0] LCD_IDLE_WORD =
    LCD_DW'((1 << LCD_CTL_CS_BIT) | (1 << LCD_CTL_DC_BIT));

  localparam int LCD_TIMEOUT_DEF = 50000;
  localparam int LCD_TO_W_DEF    = 16;

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module lcd_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            vld
);

  logic [PW-1:0] j;

  // Walk ptr+1 .. ptr+NREQ (mod NREQ); the first hit wins, so ptr itself is last.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = PW'((int'(ptr) + i) % NREQ);
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/lcd_spi_arbiter.sv
// Shares the LCD SPI write engine between NREQ command sources.
// Round-robin per word, Req_Lock keeps the grant across a burst, and a
// watchdog aborts a transfer the engine never completes.
module lcd_spi_arbiter
  import lcd_spi_pkg::*;
#(
  parameter int              NREQ      = 3,
  parameter int              DW        = LCD_DW,
  parameter logic [DW-1:0]   IDLE_WORD = LCD_IDLE_WORD,
  parameter int              TIMEOUT   = LCD_TIMEOUT_DEF,
  parameter int              TO_W      = LCD_TO_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      Req_Start_Sig,
  input  logic [NREQ-1:0]      Req_Lock,
  input  logic [NREQ*DW-1:0]   Req_Data,
  output logic [NREQ-1:0]      Req_Done_Sig,
  output logic                 SPI_Start_Sig,
  output logic [DW-1:0]        SPI_Data,
  input  logic                 SPI_Done_Sig,
  output logic [NREQ-1:0]      Grant,
  output logic                 Busy,
  output logic                 Timeout_Sig
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  lcd_state_e           state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 spi_start_q, spi_start_d;
  logic [DW-1:0]        spi_data_q, spi_data_d;
  logic [TO_W-1:0]      wd_q, wd_d;
  logic                 timeout_q, timeout_d;

  logic [NREQ-1:0][DW-1:0] req_word;
  logic [NREQ-1:0]      pick_gnt;
  logic [PW-1:0]        pick_idx;
  logic                 pick_vld;
  logic                 in_busy;
  logic                 wd_hit;

  assign req_word = Req_Data;
  assign in_busy  = (state_q == ST_BUSY);
  assign wd_hit   = in_busy && (wd_q == TO_W'(TIMEOUT - 1));

  lcd_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (Req_Start_Sig),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Next-state, grant/pointer bookkeeping, output word and watchdog.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    spi_start_d = spi_start_q;
    spi_data_d  = spi_data_q;
    wd_d        = '0;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d     = pick_gnt;
          gidx_d      = pick_idx;
          spi_data_d  = req_word[pick_idx];
          spi_start_d = 1'b1;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        wd_d = wd_q + TO_W'(1);
        // A done on the watchdog's last cycle still counts as a clean finish.
        if (SPI_Done_Sig || wd_hit) begin
          spi_start_d = 1'b0;
          spi_data_d  = IDLE_WORD;
          timeout_d   = !SPI_Done_Sig;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        // One dead cycle lets the owner drop its start before we look again.
        if (Req_Lock[gidx_q]) begin
          state_d = ST_HOLD;
        end else begin
          grant_d = '0;
          ptr_d   = gidx_q;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (Req_Start_Sig[gidx_q]) begin
          spi_data_d  = req_word[gidx_q];
          spi_start_d = 1'b1;
          state_d     = ST_BUSY;
        end else if (!Req_Lock[gidx_q]) begin
          grant_d = '0;
          ptr_d   = gidx_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset parks the bus with requester 0 first in line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= PW'(NREQ - 1);
      spi_start_q <= 1'b0;
      spi_data_q  <= IDLE_WORD;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
    end
  end

  assign Req_Done_Sig  = grant_q & {NREQ{(SPI_Done_Sig | wd_hit) & in_busy}};
  assign SPI_Start_Sig = spi_start_q;
  assign SPI_Data      = spi_data_q;
  assign Grant         = grant_q;
  assign Busy          = (state_q != ST_IDLE);
  assign Timeout_Sig   = timeout_q;

endmodule
